// File: rtl/dpwm_pkg.sv
// Shared types and defaults for the 4-phase DPWM sequencer.
package dpwm_pkg;

  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned NUM_PHASES = 4;
  localparam int unsigned SEL_W      = $clog2(NUM_PHASES);

  // Sequencer FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/dpwm_phase_sequencer_if.sv
// Configuration inputs and decoder-facing outputs of the DPWM phase sequencer.
interface dpwm_phase_sequencer_if
  import dpwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             busy;
  logic             slot_done;
  logic             cycle_done;
  logic             cfg_err;

  modport master (
    output start, stop, period, duty,
    input  sel, en, busy, slot_done, cycle_done, cfg_err
  );

  modport slave (
    input  start, stop, period, duty,
    output sel, en, busy, slot_done, cycle_done, cfg_err
  );

endinterface

// File: rtl/dpwm_slot_counter.sv
// Per-slot clock counter; wrap flags the last clock of a slot.
module dpwm_slot_counter
  import dpwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] per_s,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  // Last clock of the slot; per_s is never 0 while enabled
  assign wrap = enable && (cnt == per_s - CNT_W'(1));

  // Count up through the slot and wrap to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dpwm_phase_sequencer.sv
// Four-phase interleaved DPWM sequencer driving an external 2-to-4 decoder.
// Optional feature: define DPWM_DEADTIME_EN to hold EN low for the first DEAD
// clocks of every slot.
module dpwm_phase_sequencer
  import dpwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DEAD  = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  dpwm_phase_sequencer_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST_PH = SEL_W'(NUM_PHASES - 1);

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] per_s;
  logic [CNT_W-1:0] dty_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_nxt;
  logic             en_q;
  logic             busy_q;
  logic             slot_done_q;
  logic             cycle_done_q;
  logic             cfg_err_q;
  logic             stop_pend;
  logic             in_run;
  logic             wrap;
  logic             cycle_end;
  logic             en_nxt;
  logic             last_nxt;

  // Dead time must be representable by the slot counter
  if ((DEAD >> CNT_W) != 0) begin : g_dead_chk
    $error("DEAD does not fit in CNT_W bits");
  end

  assign in_run    = (state == ST_RUN);
  assign cycle_end = wrap && (sel_q == LAST_PH);

  dpwm_slot_counter #(.CNT_W(CNT_W)) u_slot_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_run),
    .enable (in_run),
    .per_s  (per_s),
    .cnt    (cnt),
    .wrap   (wrap)
  );

  // Next state plus look-ahead of counter/phase so outputs register aligned
  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE: if (bus.start && (bus.period != '0)) nxt_state = ST_LOAD;
      ST_LOAD: nxt_state = ST_RUN;
      ST_RUN: begin
        if (cycle_end) begin
          nxt_state = (bus.start && !stop_pend && !bus.stop && (bus.period != '0))
                      ? ST_LOAD : ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    cnt_nxt = '0;
    if (in_run && !wrap) cnt_nxt = cnt + CNT_W'(1);

    sel_nxt = wrap ? sel_q + SEL_W'(1) : sel_q;

`ifdef DPWM_DEADTIME_EN
    en_nxt = (nxt_state == ST_RUN) && (cnt_nxt >= CNT_W'(DEAD)) && (cnt_nxt < dty_s);
`else
    en_nxt = (nxt_state == ST_RUN) && (cnt_nxt < dty_s);
`endif

    last_nxt = (nxt_state == ST_RUN) && (cnt_nxt == per_s - CNT_W'(1));
  end

  // FSM, shadow registers, stop latch, sticky error and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      per_s        <= '0;
      dty_s        <= '0;
      sel_q        <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      slot_done_q  <= 1'b0;
      cycle_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      stop_pend    <= 1'b0;
    end else begin
      state        <= nxt_state;
      sel_q        <= sel_nxt;
      en_q         <= en_nxt;
      busy_q       <= (nxt_state != ST_IDLE);
      slot_done_q  <= last_nxt;
      cycle_done_q <= last_nxt && (sel_nxt == LAST_PH);
      stop_pend    <= (nxt_state == ST_RUN) && (stop_pend || bus.stop);
      if (nxt_state == ST_LOAD) begin
        per_s     <= bus.period;
        dty_s     <= bus.duty;
        cfg_err_q <= 1'b0;
      end else if ((state == ST_IDLE) && bus.start && (bus.period == '0)) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  assign bus.sel        = sel_q;
  assign bus.en         = en_q;
  assign bus.busy       = busy_q;
  assign bus.slot_done  = slot_done_q;
  assign bus.cycle_done = cycle_done_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_dpwm_phase_sequencer.sv
// Scoreboard bench for the DPWM phase sequencer: the driver queues the expected
// outputs for every clock, a negedge monitor pops and compares them.
module tb_dpwm_phase_sequencer;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEAD  = 2;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       sd;
    logic       cd;
    logic       err;
  } exp_t;

  bit   clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  dpwm_phase_sequencer_if #(.CNT_W(CNT_W)) bus ();

  dpwm_phase_sequencer #(.CNT_W(CNT_W), .DEAD(DEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  // Cycle index used to align queued expectations with the monitor
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] sel, input logic en, input logic busy,
                              input logic sd, input logic cd, input logic err);
    exp_t e;
    e.cyc  = 0;
    e.sel  = sel;
    e.en   = en;
    e.busy = busy;
    e.sd   = sd;
    e.cd   = cd;
    e.err  = err;
    return e;
  endfunction

  function automatic logic en_exp(input int c, input int dty);
`ifdef DPWM_DEADTIME_EN
    return (c >= int'(DEAD)) && (c < dty);
`else
    return c < dty;
`endif
  endfunction

  // Queue the outputs expected after the next rising edge, then advance
  task automatic tick(input exp_t e);
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_tick(input logic err);
    tick(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, err));
  endtask

  task automatic load_tick();
    tick(mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  // n RUN clocks of a cycle; kind 1 = set duty, 2 = stop pulse, 3 = drop start
  task automatic run_cycle(input int per, input int dty, input int n,
                           input int ev_at, input int kind, input int val);
    for (int i = 0; i < n; i++) begin
      int s;
      int c;
      s = i / per;
      c = i % per;
      if (i == ev_at) begin
        case (kind)
          1:       bus.duty = 8'(val);
          2:       bus.stop = 1'b1;
          3:       bus.start = 1'b0;
          default: ;
        endcase
      end
      tick(mk(2'(s), en_exp(c, dty), 1'b1, c == per - 1,
              (c == per - 1) && (s == 3), 1'b0));
      bus.stop = 1'b0;
    end
  endtask

  // Monitor: compare every queued expectation that falls due this cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL stale cyc=%0d got=none exp=entry_for_cyc_%0d", cyc, e.cyc);
      end else begin
        chk("sel",        bus.sel,               e.sel);
        chk("en",         {1'b0, bus.en},         {1'b0, e.en});
        chk("busy",       {1'b0, bus.busy},       {1'b0, e.busy});
        chk("slot_done",  {1'b0, bus.slot_done},  {1'b0, e.sd});
        chk("cycle_done", {1'b0, bus.cycle_done}, {1'b0, e.cd});
        chk("cfg_err",    {1'b0, bus.cfg_err},    {1'b0, e.err});
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.period = '0;
    bus.duty   = '0;
    @(negedge clk);
    idle_tick(1'b0);
    rst_n = 1'b1;
    idle_tick(1'b0);

    // Basic pattern, then duty 0, duty 9 and a mid-cycle duty change
    bus.start = 1'b1; bus.period = 8'd4; bus.duty = 8'd2;
    load_tick();
    run_cycle(4, 2, 16, -1, 0, 0); load_tick();
    run_cycle(4, 2, 16, 0, 1, 0);  load_tick();
    run_cycle(4, 0, 16, 0, 1, 9);  load_tick();
    run_cycle(4, 9, 16, 0, 1, 2);  load_tick();
    run_cycle(4, 2, 16, 5, 1, 3);  load_tick();

    // Stop during slot 1: cycle completes, one idle clock, START still high
    run_cycle(4, 3, 16, 6, 2, 0);
    idle_tick(1'b0);
    load_tick();
    // START dropped mid-cycle
    run_cycle(4, 3, 16, 0, 3, 0);
    idle_tick(1'b0);

    // Zero period flags an error, a valid start clears it
    bus.period = 8'd0; bus.start = 1'b1;
    idle_tick(1'b1);
    idle_tick(1'b1);
    bus.period = 8'd3; bus.duty = 8'd1;
    load_tick();
    run_cycle(3, 1, 12, -1, 0, 0);
    // Stop coincident with CYCLE_DONE
    bus.stop = 1'b1; bus.period = 8'd4; bus.duty = 8'd2;
    idle_tick(1'b0);
    bus.stop = 1'b0;
    load_tick();

    // Reset mid-run at SEL=2, EN=1 clears outputs without a clock edge
    run_cycle(4, 2, 9, -1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sel",        bus.sel,               2'd0);
    chk("async_en",         {1'b0, bus.en},         2'd0);
    chk("async_busy",       {1'b0, bus.busy},       2'd0);
    chk("async_slot_done",  {1'b0, bus.slot_done},  2'd0);
    chk("async_cycle_done", {1'b0, bus.cycle_done}, 2'd0);
    chk("async_cfg_err",    {1'b0, bus.cfg_err},    2'd0);
    bus.start = 1'b0;
    idle_tick(1'b0);
    rst_n = 1'b1;
    idle_tick(1'b0);

    // Period 6, duty 4 (dead-time pattern when enabled)
    bus.start = 1'b1; bus.period = 8'd6; bus.duty = 8'd4;
    load_tick();
    run_cycle(6, 4, 24, 0, 3, 0);
    idle_tick(1'b0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got=%0d_pending exp=0_pending", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
